// File: rtl/lebug_pkg.sv
// Shared definitions for the vector scalar-reduction stage.
// Holds the op encodings and a small width helper.
package lebug_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SUM  = 2'd1,
        OP_MAX  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    function automatic int chain_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reduce_tree.sv
// Combinational N-lane wrapping-sum and signed-max reduction.
// Heap-shaped tree: leaves at N..2N-1, root at node 1.
module reduce_tree #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic [N*DATA_WIDTH-1:0] vec_i,
    output logic [DATA_WIDTH-1:0]   sum_o,
    output logic [DATA_WIDTH-1:0]   max_o
);

    logic [DATA_WIDTH-1:0] sum_n [1:2*N-1];
    logic [DATA_WIDTH-1:0] max_n [1:2*N-1];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign sum_n[N+i] = vec_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign max_n[N+i] = vec_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar i = 1; i < N; i++) begin : g_node
        assign sum_n[i] = sum_n[2*i] + sum_n[2*i+1];
        assign max_n[i] =
            ($signed(max_n[2*i]) > $signed(max_n[2*i+1]))
            ? max_n[2*i] : max_n[2*i+1];
    end

    assign sum_o = sum_n[1];
    assign max_o = max_n[1];

endmodule

// File: rtl/vector_scalar_reduce.sv
// Three-stage vector-to-scalar reduction with per-chain firmware
// (op, accumulate flag) and per-chain frame accumulators.
module vector_scalar_reduce
    import lebug_pkg::*;
#(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter logic [1:0] INITIAL_FIRMWARE_OP [0:MAX_CHAINS-1] =
        '{default: 2'd0},
    parameter logic INITIAL_FIRMWARE_ACC [0:MAX_CHAINS-1] =
        '{default: 1'b0},
    localparam int CW = chain_w(MAX_CHAINS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tracing,
    input  logic                    valid_in,
    input  logic                    eof_in,
    input  logic [CW-1:0]           chainId_in,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic [CW-1:0]           chainId_out,
    output logic                    valid_out,
    output logic                    eof_out
);

    localparam int VW = N * DATA_WIDTH;
    localparam int PW = $clog2(2 * MAX_CHAINS);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    op_e                   fw_op_q  [MAX_CHAINS];
    logic                  fw_acc_q [MAX_CHAINS];
    logic [PW-1:0]         ptr_q;

    logic                  s1_valid_q, s1_acc_q, s1_eof_q;
    op_e                   s1_op_q;
    logic [CW-1:0]         s1_chain_q;
    logic [VW-1:0]         s1_vec_q;

    logic                  s2_valid_q, s2_acc_q, s2_eof_q;
    op_e                   s2_op_q;
    logic [CW-1:0]         s2_chain_q;
    logic [VW-1:0]         s2_vec_q, s2_vec_d;
    logic [DATA_WIDTH-1:0] s2_red_q, s2_red_d;

    logic [DATA_WIDTH-1:0] sum_acc_q [MAX_CHAINS];
    logic [DATA_WIDTH-1:0] max_acc_q [MAX_CHAINS];

    logic [DATA_WIDTH-1:0] tree_sum, tree_max;
    logic [DATA_WIDTH-1:0] cur_sum, cur_max, acc_val;
    logic                  acc_path, take;

    assign take = tracing && valid_in;

    // Firmware and config pointer; a consumed vector sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int i = 0; i < MAX_CHAINS; i++) begin
                fw_op_q[i]  <= op_e'(INITIAL_FIRMWARE_OP[i]);
                fw_acc_q[i] <= INITIAL_FIRMWARE_ACC[i];
            end
        end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
            for (int i = 0; i < MAX_CHAINS; i++) begin
                if (ptr_q == PW'(i))
                    fw_op_q[i] <= op_e'(configData[1:0]);
                if (ptr_q == PW'(MAX_CHAINS + i))
                    fw_acc_q[i] <= configData[0];
            end
            ptr_q <= (ptr_q == PW'(2*MAX_CHAINS-1))
                     ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s1_valid_q <= 1'b0;
        else       s1_valid_q <= take;
        if (take) begin
            s1_op_q    <= fw_op_q[chainId_in];
            s1_acc_q   <= fw_acc_q[chainId_in];
            s1_eof_q   <= eof_in;
            s1_chain_q <= chainId_in;
            s1_vec_q   <= vector_in;
        end
    end

    reduce_tree #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .vec_i (s1_vec_q),
        .sum_o (tree_sum),
        .max_o (tree_max)
    );

    always_comb begin
        s2_red_d = (s1_op_q == OP_MAX) ? tree_max : tree_sum;
        s2_vec_d = s1_vec_q;
        if (s1_op_q == OP_SUM || s1_op_q == OP_MAX)
            s2_vec_d = VW'(s2_red_d);
    end

    always_ff @(posedge clk) begin
        if (reset) s2_valid_q <= 1'b0;
        else       s2_valid_q <= s1_valid_q;
        s2_op_q    <= s1_op_q;
        s2_acc_q   <= s1_acc_q;
        s2_eof_q   <= s1_eof_q;
        s2_chain_q <= s1_chain_q;
        s2_vec_q   <= s2_vec_d;
        s2_red_q   <= s2_red_d;
    end

    always_comb begin
        acc_path = s2_acc_q &&
                   (s2_op_q == OP_SUM || s2_op_q == OP_MAX);
        cur_sum  = sum_acc_q[s2_chain_q] + s2_red_q;
        cur_max  = ($signed(s2_red_q) >
                    $signed(max_acc_q[s2_chain_q]))
                   ? s2_red_q : max_acc_q[s2_chain_q];
        acc_val  = (s2_op_q == OP_SUM) ? cur_sum : cur_max;
    end

    // Each vector combines with the op it carried, so both
    // identities are kept per chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            vector_out  <= '0;
            chainId_out <= '0;
            for (int i = 0; i < MAX_CHAINS; i++) begin
                sum_acc_q[i] <= '0;
                max_acc_q[i] <= MIN_NEG;
            end
        end else begin
            valid_out <= 1'b0;
            eof_out   <= 1'b0;
            if (s2_valid_q) begin
                if (!acc_path) begin
                    valid_out   <= 1'b1;
                    eof_out     <= s2_eof_q;
                    vector_out  <= s2_vec_q;
                    chainId_out <= s2_chain_q;
                end else if (s2_eof_q) begin
                    valid_out   <= 1'b1;
                    eof_out     <= 1'b1;
                    vector_out  <= VW'(acc_val);
                    chainId_out <= s2_chain_q;
                    sum_acc_q[s2_chain_q] <= '0;
                    max_acc_q[s2_chain_q] <= MIN_NEG;
                end else if (s2_op_q == OP_SUM) begin
                    sum_acc_q[s2_chain_q] <= cur_sum;
                end else begin
                    max_acc_q[s2_chain_q] <= cur_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Directed bench with a frame-level reference model and a
// per-cycle output compare process.
module tb_vector_scalar_reduce;

    localparam int PID = 5;
    localparam logic [31:0] MINNEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tracing = 1'b1;
    logic         valid_in = 1'b0;
    logic         eof_in = 1'b0;
    logic [1:0]   chainId_in = '0;
    logic [7:0]   configId = 8'hFF;
    logic [7:0]   configData = '0;
    logic [255:0] vector_in = '0;
    logic [255:0] vector_out;
    logic [1:0]   chainId_out;
    logic         valid_out;
    logic         eof_out;

    int checks = 0;
    int errors = 0;

    vector_scalar_reduce #(
        .N                    (8),
        .DATA_WIDTH           (32),
        .MAX_CHAINS           (4),
        .PERSONAL_CONFIG_ID   (PID),
        .INITIAL_FIRMWARE_OP  ('{2'd1, 2'd1, 2'd2, 2'd0}),
        .INITIAL_FIRMWARE_ACC ('{1'b0, 1'b1, 1'b0, 1'b0})
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tracing     (tracing),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .vector_out  (vector_out),
        .chainId_out (chainId_out),
        .valid_out   (valid_out),
        .eof_out     (eof_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic         eof;
        logic [1:0]   ch;
        logic [255:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  mop  [4];
    logic        macc [4];
    logic [31:0] msum [4];
    int          mmax [4];
    int          mptr;
    int          cyc = -1;
    logic        rst_edge = 1'b1;

    task automatic model_reset();
        exp_q.delete();
        mop[0] = 2'd1; mop[1] = 2'd1; mop[2] = 2'd2; mop[3] = 2'd0;
        macc[0] = 0; macc[1] = 1; macc[2] = 0; macc[3] = 0;
        for (int i = 0; i < 4; i++) begin
            msum[i] = '0;
            mmax[i] = int'(MINNEG);
        end
        mptr = 0;
    endtask

    task automatic model_consume();
        logic [31:0] s, lane;
        int m, ch;
        exp_t e;
        s = '0;
        m = int'(vector_in[31:0]);
        for (int i = 0; i < 8; i++) begin
            lane = vector_in[i*32 +: 32];
            s += lane;
            if (int'(lane) > m) m = int'(lane);
        end
        ch = int'(chainId_in);
        e.due = cyc + 2;
        e.ch = chainId_in;
        if (macc[ch] && (mop[ch] == 2'd1 || mop[ch] == 2'd2)) begin
            if (mop[ch] == 2'd1) msum[ch] += s;
            else if (m > mmax[ch]) mmax[ch] = m;
            if (eof_in) begin
                e.eof = 1'b1;
                e.vec = (mop[ch] == 2'd1)
                        ? {224'b0, msum[ch]}
                        : {224'b0, 32'(mmax[ch])};
                exp_q.push_back(e);
                msum[ch] = '0;
                mmax[ch] = int'(MINNEG);
            end
        end else begin
            e.eof = eof_in;
            if (mop[ch] == 2'd1)      e.vec = {224'b0, s};
            else if (mop[ch] == 2'd2) e.vec = {224'b0, 32'(m)};
            else                      e.vec = vector_in;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = reset;
            if (reset) begin
                model_reset();
            end else begin
                if (tracing && valid_in) model_consume();
                if (configId == 8'(PID)) begin
                    if (mptr < 4) mop[mptr] = configData[1:0];
                    else          macc[mptr-4] = configData[0];
                    mptr = (mptr + 1) % 8;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (rst_edge) begin
                if (valid_out !== 1'b0 || eof_out !== 1'b0 ||
                    vector_out !== '0 || chainId_out !== '0) begin
                    errors++;
                    $display("FAIL reset_out cyc %0d: v=%b e=%b ch=%0d vec=%h, want all 0",
                             cyc, valid_out, eof_out, chainId_out, vector_out);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (valid_out !== 1'b1 || eof_out !== e.eof ||
                    chainId_out !== e.ch || vector_out !== e.vec) begin
                    errors++;
                    $display("FAIL model cyc %0d: v=%b e=%b ch=%0d vec=%h, want v=1 e=%b ch=%0d vec=%h",
                             cyc, valid_out, eof_out, chainId_out, vector_out,
                             e.eof, e.ch, e.vec);
                end
            end else if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc %0d: valid_out=%b, want 0", cyc, valid_out);
            end
        end
    end

    function automatic logic [255:0] v8(input int a0, a1, a2, a3,
                                        input int a4, a5, a6, a7);
        return {32'(a7), 32'(a6), 32'(a5), 32'(a4),
                32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic logic [255:0] vfill(input int x);
        return v8(x, x, x, x, x, x, x, x);
    endfunction

    task automatic drive(input logic tr, input logic v,
                         input logic [1:0] ch, input logic [255:0] vec,
                         input logic eof, input logic cfg,
                         input logic [7:0] cd);
        tracing = tr; valid_in = v; chainId_in = ch;
        vector_in = vec; eof_in = eof;
        configId = cfg ? 8'(PID) : 8'hFF;
        configData = cd;
        @(negedge clk);
        tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0;
        configId = 8'hFF;
    endtask

    task automatic send(input logic [1:0] ch, input logic [255:0] vec,
                        input logic eof);
        drive(1'b1, 1'b1, ch, vec, eof, 1'b0, 8'd0);
    endtask

    task automatic cfg(input logic [7:0] b);
        drive(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, b);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic wait_out(input string nm, input logic [31:0] l0,
                            input logic eof, input logic [1:0] ch,
                            input logic hi_zero, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (valid_out !== 1'b1 && lat < 20);
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL %s: no valid_out within %0d cycles", nm, lat);
        end else if (vector_out[31:0] !== l0 || eof_out !== eof ||
                     chainId_out !== ch ||
                     (hi_zero && vector_out[255:32] !== '0)) begin
            errors++;
            $display("FAIL %s: got lane0=%h eof=%b ch=%0d hi=%h, want lane0=%h eof=%b ch=%0d",
                     nm, vector_out[31:0], eof_out, chainId_out,
                     vector_out[255:32], l0, eof, ch);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(2'd0, v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
        wait_out("sum_noacc", 32'd36, 1'b0, 2'd0, 1'b1, lat);
        chk("latency", lat, 2);

        send(2'd1, vfill(1), 1'b0);
        send(2'd1, vfill(1), 1'b0);
        send(2'd1, vfill(1), 1'b1);
        wait_out("sum_acc", 32'd24, 1'b1, 2'd1, 1'b1, lat);
        send(2'd1, vfill(1), 1'b0);
        send(2'd1, vfill(1), 1'b1);
        wait_out("sum_acc_restart", 32'd16, 1'b1, 2'd1, 1'b1, lat);

        send(2'd2, v8(-5, -3, -9, -1, -7, -2, -8, -4), 1'b1);
        wait_out("max_neg", 32'hFFFF_FFFF, 1'b1, 2'd2, 1'b1, lat);

        send(2'd0, vfill(-1), 1'b0);
        wait_out("sum_wrap", 32'hFFFF_FFF8, 1'b0, 2'd0, 1'b1, lat);

        send(2'd3, v8(10, 11, 12, 13, 14, 15, 16, 17), 1'b1);
        drive(1'b0, 1'b1, 2'd3, vfill(99), 1'b1, 1'b0, 8'd0);
        wait_out("pass_drain", 32'd10, 1'b1, 2'd3, 1'b0, lat);
        chk("pass_lane1", int'(vector_out[63:32]), 11);
        repeat (3) @(negedge clk);

        cfg(8'd1); cfg(8'd2); cfg(8'd0); cfg(8'd1);
        cfg(8'd1); cfg(8'd0); cfg(8'd0); cfg(8'd0);
        chk("model_op", int'({mop[0], mop[1], mop[2], mop[3]}), 8'b01_10_00_01);
        chk("model_acc", int'({macc[0], macc[1], macc[2], macc[3]}), 4'b1000);

        send(2'd1, v8(3, 9, -2, 0, 1, 1, 1, 1), 1'b1);
        wait_out("cfg_max", 32'd9, 1'b1, 2'd1, 1'b1, lat);
        send(2'd2, v8(5, 6, 7, 8, 9, 10, 11, 12), 1'b0);
        wait_out("cfg_pass", 32'd5, 1'b0, 2'd2, 1'b0, lat);

        drive(1'b1, 1'b1, 2'd0, vfill(2), 1'b1, 1'b1, 8'd0);
        wait_out("cfg_same_cycle", 32'd16, 1'b1, 2'd0, 1'b1, lat);
        chk("model_op0_wrap", int'(mop[0]), 0);
        send(2'd0, v8(7, 1, 1, 1, 1, 1, 1, 1), 1'b0);
        wait_out("cfg_next_cycle", 32'd7, 1'b0, 2'd0, 1'b0, lat);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cfg(8'd1); cfg(8'd1); cfg(8'd2); cfg(8'd0);
        cfg(8'd1); cfg(8'd1);

        send(2'd0, vfill(1), 1'b0);
        send(2'd1, vfill(2), 1'b0);
        send(2'd0, vfill(3), 1'b0);
        drive(1'b0, 1'b1, 2'd0, vfill(100), 1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 2'd1, vfill(100), 1'b1, 1'b0, 8'd0);
        send(2'd1, vfill(4), 1'b0);
        send(2'd0, vfill(5), 1'b1);
        send(2'd1, vfill(6), 1'b1);
        wait_out("ilv_c0", 32'd72, 1'b1, 2'd0, 1'b1, lat);
        wait_out("ilv_c1", 32'd96, 1'b1, 2'd1, 1'b1, lat);

        send(2'd1, vfill(1), 1'b0);
        send(2'd0, vfill(1), 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(2'd1, vfill(1), 1'b0);
        send(2'd1, vfill(1), 1'b1);
        wait_out("post_reset_c1", 32'd16, 1'b1, 2'd1, 1'b1, lat);
        send(2'd0, v8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
        wait_out("post_reset_c0", 32'd36, 1'b0, 2'd0, 1'b1, lat);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
